// File: rtl/load_store_unit.sv
// Load/store unit: byte/half/word loads and stores to a word-only memory.
// Ports: CLK/RST, Req_* request handshake, Resp_* response handshake,
//        *_memory word-indexed memory interface (asynchronous read).
module load_store_unit #(
   parameter int Data_Width    = 32,
   parameter int Address_Width = 32,
   parameter int Mem_Depth     = 100
) (
   input  logic                     CLK,
   input  logic                     RST,
   input  logic                     Req_Valid,
   output logic                     Req_Ready,
   input  logic                     Req_Write,
   input  logic [1:0]               Req_Size,
   input  logic                     Req_Unsigned,
   input  logic [Address_Width-1:0] Req_Address,
   input  logic [Data_Width-1:0]    Req_Wdata,
   output logic                     Resp_Valid,
   input  logic                     Resp_Ready,
   output logic [Data_Width-1:0]    Resp_Rdata,
   output logic                     Resp_Error,
   output logic [Address_Width-1:0] Address_Data_memory,
   output logic [Data_Width-1:0]    Write_Data_memory,
   output logic                     Write_Enable_memory,
   input  logic [Data_Width-1:0]    Read_Data_memory
);

   localparam int DW = Data_Width;
   localparam int AW = Address_Width;

   typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

   state_t          state_q, state_d;
   logic            wr_q, wr_d;
   logic [1:0]      size_q, size_d;
   logic            uns_q, uns_d;
   logic [1:0]      lane_q, lane_d;
   logic [DW-1:0]   wdata_q, wdata_d;
   logic [DW-1:0]   rdata_q, rdata_d;
   logic            err_q, err_d;
   logic [AW-1:0]   idx_q, idx_d;
   logic [DW-1:0]   mwd_q, mwd_d;

   logic [AW-1:0]   req_idx;
   logic            req_bad;
   logic [7:0]      rd_b;
   logic [15:0]     rd_h;
   logic [DW-1:0]   ld_val;
   logic [DW-1:0]   merged;

   assign req_idx = Req_Address >> 2;

   always_comb begin
      req_bad = 1'b0;
      unique case (Req_Size)
         2'b00: req_bad = 1'b0;
         2'b01: req_bad = Req_Address[0];
         2'b10: req_bad = |Req_Address[1:0];
         default: req_bad = 1'b1;
      endcase
      if (req_idx >= AW'(Mem_Depth)) req_bad = 1'b1;
   end

   // Lane extraction and extension of the word read back from memory.
   always_comb begin
      rd_b = Read_Data_memory[8*int'(lane_q) +: 8];
      rd_h = Read_Data_memory[16*int'(lane_q[1]) +: 16];
      unique case (size_q)
         2'b00: ld_val = {{(DW-8){~uns_q & rd_b[7]}}, rd_b};
         2'b01: ld_val = {{(DW-16){~uns_q & rd_h[15]}}, rd_h};
         default: ld_val = Read_Data_memory;
      endcase
   end

   // Sub-word store: overwrite only the addressed lane(s).
   always_comb begin
      merged = Read_Data_memory;
      unique case (size_q)
         2'b00: merged[8*int'(lane_q) +: 8] = wdata_q[7:0];
         2'b01: merged[16*int'(lane_q[1]) +: 16] = wdata_q[15:0];
         default: merged = wdata_q;
      endcase
   end

   always_comb begin
      state_d = state_q;
      wr_d    = wr_q;
      size_d  = size_q;
      uns_d   = uns_q;
      lane_d  = lane_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      idx_d   = idx_q;
      mwd_d   = mwd_q;
      unique case (state_q)
         IDLE: begin
            if (Req_Valid) begin
               wr_d    = Req_Write;
               size_d  = Req_Size;
               uns_d   = Req_Unsigned;
               lane_d  = Req_Address[1:0];
               wdata_d = Req_Wdata;
               rdata_d = '0;
               err_d   = req_bad;
               if (req_bad) begin
                  state_d = RESP;
               end else begin
                  // Memory index only moves when memory is actually used.
                  idx_d = req_idx;
                  if (Req_Write && Req_Size == 2'b10) begin
                     mwd_d   = Req_Wdata;
                     state_d = WRITE;
                  end else begin
                     state_d = READ;
                  end
               end
            end
         end
         READ: begin
            if (wr_q) begin
               mwd_d   = merged;
               state_d = WRITE;
            end else begin
               rdata_d = ld_val;
               state_d = RESP;
            end
         end
         WRITE: state_d = RESP;
         RESP: begin
            if (Resp_Ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q <= IDLE;
         wr_q    <= 1'b0;
         size_q  <= 2'b00;
         uns_q   <= 1'b0;
         lane_q  <= 2'b00;
         wdata_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
         idx_q   <= '0;
         mwd_q   <= '0;
      end else begin
         state_q <= state_d;
         wr_q    <= wr_d;
         size_q  <= size_d;
         uns_q   <= uns_d;
         lane_q  <= lane_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
         idx_q   <= idx_d;
         mwd_q   <= mwd_d;
      end
   end

   assign Req_Ready           = (state_q == IDLE);
   assign Resp_Valid          = (state_q == RESP);
   assign Write_Enable_memory = (state_q == WRITE);
   assign Resp_Rdata          = rdata_q;
   assign Resp_Error          = err_q;
   assign Address_Data_memory = idx_q;
   assign Write_Data_memory   = mwd_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Testbench for load_store_unit: directed requests, queued expectations,
// monitor compares responses and memory write strobes.
module tb_load_store_unit;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          lat;
   } exp_t;

   typedef struct {
      logic [31:0] idx;
      logic [31:0] data;
   } we_t;

   logic        CLK = 1'b0;
   logic        RST = 1'b0;
   logic        Req_Valid = 1'b0;
   logic        Req_Ready;
   logic        Req_Write = 1'b0;
   logic [1:0]  Req_Size = 2'b00;
   logic        Req_Unsigned = 1'b0;
   logic [31:0] Req_Address = '0;
   logic [31:0] Req_Wdata = '0;
   logic        Resp_Valid;
   logic        Resp_Ready = 1'b1;
   logic [31:0] Resp_Rdata;
   logic        Resp_Error;
   logic [31:0] Address_Data_memory;
   logic [31:0] Write_Data_memory;
   logic        Write_Enable_memory;
   logic [31:0] Read_Data_memory;

   logic [31:0] mem [0:99];
   exp_t        exp_q[$];
   we_t         we_q[$];
   int          pass_cnt = 0;
   int          chk_cnt = 0;
   int          cyc = 0;
   int          acc_cyc = 0;
   int          acc_cnt = 0;
   int          we_cnt = 0;
   logic        prev_v = 1'b0;

   load_store_unit dut (
      .CLK(CLK),
      .RST(RST),
      .Req_Valid(Req_Valid),
      .Req_Ready(Req_Ready),
      .Req_Write(Req_Write),
      .Req_Size(Req_Size),
      .Req_Unsigned(Req_Unsigned),
      .Req_Address(Req_Address),
      .Req_Wdata(Req_Wdata),
      .Resp_Valid(Resp_Valid),
      .Resp_Ready(Resp_Ready),
      .Resp_Rdata(Resp_Rdata),
      .Resp_Error(Resp_Error),
      .Address_Data_memory(Address_Data_memory),
      .Write_Data_memory(Write_Data_memory),
      .Write_Enable_memory(Write_Enable_memory),
      .Read_Data_memory(Read_Data_memory)
   );

   always #5 CLK = ~CLK;

   assign Read_Data_memory = (Address_Data_memory < 100)
                             ? mem[Address_Data_memory[6:0]] : 32'h0;

   always @(posedge CLK) begin
      if (Write_Enable_memory && Address_Data_memory < 100)
         mem[Address_Data_memory[6:0]] <= Write_Data_memory;
   end

   always @(posedge CLK) begin
      cyc++;
      if (RST && Req_Valid && Req_Ready) begin
         acc_cyc = cyc;
         acc_cnt++;
      end
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      chk_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   // Monitor: write strobes and response handshakes against the queues.
   always @(negedge CLK) begin
      if (Write_Enable_memory) begin
         we_cnt++;
         if (we_q.size() == 0) begin
            chk("we_unexpected", 32'd1, 32'd0);
         end else begin
            chk("we_index", Address_Data_memory, we_q[0].idx);
            chk("we_data", Write_Data_memory, we_q[0].data);
            void'(we_q.pop_front());
         end
      end
      if (Resp_Valid) begin
         if (exp_q.size() == 0) begin
            chk("resp_unexpected", 32'd1, 32'd0);
         end else begin
            if (!prev_v)
               chk("latency", 32'(cyc - acc_cyc + 1), 32'(exp_q[0].lat));
            if (Resp_Ready) begin
               chk("rdata", Resp_Rdata, exp_q[0].rdata);
               chk("error", {31'd0, Resp_Error}, {31'd0, exp_q[0].err});
               void'(exp_q.pop_front());
            end
         end
      end
      prev_v = Resp_Valid;
   end

   task automatic issue(input logic w, input logic [1:0] sz,
                        input logic u, input logic [31:0] a,
                        input logic [31:0] d);
      int n = 0;
      @(negedge CLK);
      Req_Valid    = 1'b1;
      Req_Write    = w;
      Req_Size     = sz;
      Req_Unsigned = u;
      Req_Address  = a;
      Req_Wdata    = d;
      while (!Req_Ready && n < 20) begin
         @(negedge CLK);
         n++;
      end
      chk("req_ready", {31'd0, Req_Ready}, 32'd1);
      @(posedge CLK);
      #1 Req_Valid = 1'b0;
   endtask

   task automatic wait_done();
      int n = 0;
      while ((exp_q.size() != 0 || we_q.size() != 0) && n < 50) begin
         @(negedge CLK);
         n++;
      end
      if (exp_q.size() != 0 || we_q.size() != 0) begin
         chk("timeout", 32'(exp_q.size() + we_q.size()), 32'd0);
         exp_q.delete();
         we_q.delete();
      end
   endtask

   task automatic req(input logic w, input logic [1:0] sz,
                      input logic u, input logic [31:0] a,
                      input logic [31:0] d, input logic [31:0] er,
                      input logic ee, input int lat,
                      input logic has_we, input logic [31:0] wi,
                      input logic [31:0] wd);
      exp_t e;
      we_t  x;
      e.rdata = er;
      e.err   = ee;
      e.lat   = lat;
      exp_q.push_back(e);
      if (has_we) begin
         x.idx  = wi;
         x.data = wd;
         we_q.push_back(x);
      end
      issue(w, sz, u, a, d);
      wait_done();
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int acc0;
      int we0;
      for (int i = 0; i < 100; i++) mem[i] = '0;
      repeat (2) @(negedge CLK);
      chk("rst_req_ready", {31'd0, Req_Ready}, 32'd1);
      chk("rst_resp_valid", {31'd0, Resp_Valid}, 32'd0);
      chk("rst_we", {31'd0, Write_Enable_memory}, 32'd0);
      chk("rst_rdata", Resp_Rdata, 32'd0);
      chk("rst_error", {31'd0, Resp_Error}, 32'd0);
      chk("rst_addr", Address_Data_memory, 32'd0);
      chk("rst_wdata", Write_Data_memory, 32'd0);
      RST = 1'b1;

      // word store / load
      req(1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 0, 0, 2, 1, 4, 32'hDEADBEEF);
      req(0, 2'b10, 0, 32'h10, 0, 32'hDEADBEEF, 0, 2, 0, 0, 0);
      // byte store, signed and unsigned byte loads
      req(1, 2'b00, 0, 32'h11, 32'hAA, 0, 0, 3, 1, 4, 32'hDEADAAEF);
      req(0, 2'b00, 0, 32'h11, 0, 32'hFFFFFFAA, 0, 2, 0, 0, 0);
      req(0, 2'b00, 1, 32'h11, 0, 32'h000000AA, 0, 2, 0, 0, 0);
      // halfword store and loads
      req(1, 2'b01, 0, 32'h12, 32'h1234, 0, 0, 3, 1, 4, 32'h1234AAEF);
      req(0, 2'b01, 0, 32'h12, 0, 32'h00001234, 0, 2, 0, 0, 0);
      req(0, 2'b01, 0, 32'h10, 0, 32'hFFFFAAEF, 0, 2, 0, 0, 0);
      req(0, 2'b01, 1, 32'h10, 0, 32'h0000AAEF, 0, 2, 0, 0, 0);
      req(0, 2'b00, 0, 32'h13, 0, 32'h00000012, 0, 2, 0, 0, 0);
      // error cases: no write strobe expected
      we0 = we_cnt;
      req(0, 2'b01, 0, 32'h13, 0, 0, 1, 1, 0, 0, 0);
      req(0, 2'b10, 0, 32'h190, 0, 0, 1, 1, 0, 0, 0);
      req(0, 2'b11, 0, 32'h10, 0, 0, 1, 1, 0, 0, 0);
      req(1, 2'b10, 0, 32'h11, 32'h55, 0, 1, 1, 0, 0, 0);
      req(1, 2'b00, 0, 32'h190, 32'h55, 0, 1, 1, 0, 0, 0);
      req(0, 2'b10, 0, 32'h18C, 0, 0, 0, 2, 0, 0, 0);
      chk("err_no_we", 32'(we_cnt - we0), 32'd0);
      chk("mem4", mem[4], 32'h1234AAEF);

      // backpressure: response held, new request ignored
      begin
         exp_t e;
         e.rdata = 32'h1234AAEF;
         e.err   = 1'b0;
         e.lat   = 2;
         exp_q.push_back(e);
      end
      Resp_Ready = 1'b0;
      issue(0, 2'b10, 0, 32'h10, 0);
      acc0 = acc_cnt;
      @(negedge CLK);
      Req_Valid   = 1'b1;
      Req_Write   = 1'b1;
      Req_Size    = 2'b10;
      Req_Address = 32'h20;
      Req_Wdata   = 32'h0BADF00D;
      for (int i = 0; i < 5; i++) begin
         @(negedge CLK);
         chk("hold_valid", {31'd0, Resp_Valid}, 32'd1);
         chk("hold_rdata", Resp_Rdata, 32'h1234AAEF);
         chk("hold_req_ready", {31'd0, Req_Ready}, 32'd0);
      end
      Req_Valid  = 1'b0;
      Resp_Ready = 1'b1;
      wait_done();
      @(negedge CLK);
      chk("hold_no_accept", 32'(acc_cnt - acc0), 32'd0);
      chk("mem8", mem[8], 32'd0);

      // reset while a byte store sits in READ
      we0 = we_cnt;
      issue(1, 2'b00, 0, 32'h14, 32'h55);
      @(negedge CLK);
      RST = 1'b0;
      @(negedge CLK);
      chk("rst_mid_ready", {31'd0, Req_Ready}, 32'd1);
      chk("rst_mid_valid", {31'd0, Resp_Valid}, 32'd0);
      RST = 1'b1;
      repeat (3) @(negedge CLK);
      chk("rst_mid_we", 32'(we_cnt - we0), 32'd0);
      chk("rst_mid_mem5", mem[5], 32'd0);
      chk("rst_mid_ready2", {31'd0, Req_Ready}, 32'd1);
      req(0, 2'b10, 0, 32'h14, 0, 32'd0, 0, 2, 0, 0, 0);
      req(0, 2'b10, 0, 32'h10, 0, 32'h1234AAEF, 0, 2, 0, 0, 0);

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
